// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The unit sits on the slave modport; the core/memory side uses master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one byte/halfword/word access at a time,
// performs read-modify-write for sub-word stores against a word-wide memory
// and returns a one-cycle completion pulse with the extended load data.
module load_store_unit (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;

  logic        ready_c;
  logic        accept;
  logic        mem_we_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wd_c;

  // Misaligned halfword/word or an encoding RV32I does not define.
  function automatic logic illegal_req(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] a);
    logic bad;
    if (we) bad = (funct3 > 3'd2);
    else    bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    if ((funct3[1:0] == 2'd1) && a[0])          bad = 1'b1;
    if ((funct3[1:0] == 2'd2) && (a != 2'b00))  bad = 1'b1;
    return bad;
  endfunction

  // Pick the addressed byte/halfword out of the word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  a);
    logic [31:0]        shifted;
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] ext;
    shifted = word >> {a, 3'b000};
    b       = shifted[7:0];
    h       = a[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'd0:    ext = $signed(b);
      3'd1:    ext = $signed(h);
      3'd4:    ext = $signed({24'd0, b});
      3'd5:    ext = $signed({16'd0, h});
      default: ext = $signed(word);
    endcase
    return ext;
  endfunction

  // Replace the addressed byte (funct3[0]=0) or halfword (funct3[0]=1) in word.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  a);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] data;
    if (funct3[0]) begin
      sh   = {a[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
      data = {16'd0, wdata[15:0]} << sh;
    end else begin
      sh   = {a, 3'b000};
      mask = 32'h0000_00FF << sh;
      data = {24'd0, wdata[7:0]} << sh;
    end
    return (word & ~mask) | (data & mask);
  endfunction

  assign ready_c = rst_n && (state == IDLE);
  assign accept  = bus.req_valid && ready_c;

  // Capture the request on acceptance; held stable for the whole operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
      we_q     <= bus.req_we;
    end
  end

  // Control FSM with registered response outputs and merged store word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
      merged_q     <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal_req(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              rdata_q      <= 32'd0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            rdata_q      <= load_extend(bus.mem_rd, funct3_q, addr_q[1:0]);
          end else if (funct3_q[1:0] == 2'd2) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
          end else begin
            state    <= WRITE;
            merged_q <= merge_store(bus.mem_rd, wdata_q, funct3_q, addr_q[1:0]);
          end
        end
        WRITE: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          rdata_q      <= 32'd0;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port decode; write strobe is suppressed while reset is held so an
  // aborted store never reaches memory.
  always_comb begin
    mem_we_c   = 1'b0;
    mem_wd_c   = 32'd0;
    mem_addr_c = 32'd0;
    case (state)
      ACCESS: begin
        mem_addr_c = {addr_q[31:2], 2'b00};
        if (rst_n && we_q && (funct3_q[1:0] == 2'd2)) begin
          mem_we_c = 1'b1;
          mem_wd_c = wdata_q;
        end
      end
      WRITE: begin
        mem_addr_c = {addr_q[31:2], 2'b00};
        if (rst_n) begin
          mem_we_c = 1'b1;
          mem_wd_c = merged_q;
        end
      end
      default: begin
        mem_we_c = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wd     = mem_wd_c;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus a random load/store stream
// checked against a byte-addressed reference memory through a scoreboard.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word-wide data memory seen by the DUT (1 KiB window, upper bits alias).
  logic [31:0] dmem [0:255];
  // Reference memory, one entry per byte.
  logic [7:0]  ref_b [0:1023];

  assign bus.mem_rd = dmem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we === 1'b1) dmem[bus.mem_addr[9:2]] <= bus.mem_wd;

  int cyc = 0;
  int we_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_we === 1'b1) we_seen <= we_seen + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  logic busy = 1'b0;
  logic mon_en = 1'b0;
  int   we_base = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;
  int          last_lat = 0;
  int          last_nwe = 0;

  // Reference behaviour: byte-granular memory, RV32I width/sign rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   a, size, v;
    bit   illegal;
    e.rdata = 0; e.err = 0; e.nwe = 0; e.acc = 0; e.lat = 0;
    a = int'(addr[9:0]);
    if (we) illegal = (f3 > 2);
    else    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
    size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    if ((a % size) != 0) illegal = 1;
    if (illegal) begin
      e.err = 1; e.lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_b[a + i] = wd[8*i +: 8];
      e.lat = (size == 4) ? 2 : 3;
      e.nwe = 1;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (int'(ref_b[a + i]) << (8 * i));
      if (f3 == 0 && v >= 128)   v -= 256;
      if (f3 == 1 && v >= 32768) v -= 65536;
      e.rdata = v;
      e.lat   = 2;
    end
    return e;
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    dmem[addr[9:2]] = val;
    for (int i = 0; i < 4; i++) ref_b[{addr[9:2], 2'b00} + i] = val[8*i +: 8];
  endtask

  // Present one request, wait for acceptance, then scramble req_* fields.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   guard;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready stuck at %b, required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    e = model(we, f3, addr, wd);
    e.acc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    busy = 1'b1;
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || busy) && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 100) begin
      total++; bad++;
      $display("FAIL idle_timeout: %0d responses outstanding, required 0", sb_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each completion and watches bus rules.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && rst_n === 1'b1) begin
      check("mem_addr_align", {30'd0, bus.mem_addr[1:0]}, 32'd0);
      if (bus.mem_we !== 1'b1) check("mem_wd_idle", bus.mem_wd, 32'd0);
      if (!busy) check("mem_we_idle", {31'd0, bus.mem_we}, 32'd0);
      if (busy) check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      if (bus.resp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_rdata", bus.resp_rdata, mon_e.rdata);
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, mon_e.err});
          check("latency", cyc - mon_e.acc + 1, mon_e.lat);
          check("mem_we_count", we_seen - we_base, mon_e.nwe);
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
          last_lat   = cyc - mon_e.acc + 1;
          last_nwe   = we_seen - we_base;
        end
        we_base = we_seen;
        busy    = 1'b0;
      end
    end
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  ld_ok [5];
    int          base;

    ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int w = 0; w < 256; w++) set_word(32'(w * 4), $urandom);
    set_word(32'h100, 32'h8899AABB);
    set_word(32'h200, 32'h11223344);
    set_word(32'h2C0, 32'hCAFEF00D);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_ready", {31'd0, bus.req_ready}, 32'd1);
    mon_en = 1'b1;

    // Directed loads of 0x8899AABB
    issue(1'b0, 3'd0, 32'h101, 32'h0); wait_idle();
    check("lb_101", last_rdata, 32'hFFFFFFAA);
    check("lb_101_lat", last_lat, 2);
    issue(1'b0, 3'd5, 32'h102, 32'h0); wait_idle();
    check("lhu_102", last_rdata, 32'h00008899);
    issue(1'b0, 3'd1, 32'h102, 32'h0); wait_idle();
    check("lh_102", last_rdata, 32'hFFFF8899);

    // Byte store with read-modify-write
    issue(1'b1, 3'd0, 32'h203, 32'hDEADBEEF); wait_idle();
    check("sb_203_word", dmem[8'h80], 32'hEF223344);
    check("sb_203_lat", last_lat, 3);
    check("sb_203_we", last_nwe, 1);

    // Error cases
    issue(1'b1, 3'd2, 32'h206, 32'h12345678); wait_idle();
    check("sw_206_err", {31'd0, last_err}, 32'd1);
    check("sw_206_lat", last_lat, 1);
    check("sw_206_we", last_nwe, 0);
    issue(1'b0, 3'd3, 32'h300, 32'h0); wait_idle();
    check("ld_f3_3_err", {31'd0, last_err}, 32'd1);
    check("ld_f3_3_rdata", last_rdata, 32'd0);

    // Top-of-address-space word
    issue(1'b1, 3'd2, 32'hFFFFFFFC, 32'hA5A55A5A);
    issue(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0); wait_idle();
    check("lw_top", last_rdata, 32'hA5A55A5A);
    check("lw_top_err", {31'd0, last_err}, 32'd0);

    // Reset asserted during the WRITE cycle of a halfword store
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd1;
    bus.req_addr = 32'h2C2; bus.req_wdata = 32'h00001234;
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    busy = 1'b1;
    base = we_seen;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    check("abort_ready_rst", {31'd0, bus.req_ready}, 32'd0);
    check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    busy = 1'b0;
    rst_n = 1'b1;
    #1;
    check("abort_release_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_we_count", we_seen - base, 0);
    check("abort_word", dmem[8'hB0], 32'hCAFEF00D);
    we_base = we_seen;

    // Random stream
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_ok[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
        if (f3[1:0] == 2'd1) addr[0]   = 1'b0;
      end
      issue(we, f3, addr, $urandom);
    end
    wait_idle();

    // Final memory image
    for (int w = 0; w < 256; w++)
      check("final_mem", dmem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
